// File: rtl/game_pkg.sv
// Shared definitions for the game datapath.
//   - Screen geometry of the 160x120 VGA grid and the matching coordinate widths.
//   - State encoding of the spawn position generator FSM.
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COORD_XW = 8;
    localparam int COORD_YW = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_FOLD   = 3'd3,
        ST_HOLD   = 3'd4
    } spawn_state_e;

endpackage

// File: rtl/spawn_pos_gen.sv
// Spawn position generator.
// Turns the free-running 13-bit LFSR word into an on-screen spawn coordinate.
// Samples are rejected when off-screen or equal to the previously issued
// position; after MAX_TRY rejected samples the last sample is folded into
// range instead, so every request completes in bounded time.
//
// Handshake: a request is taken only in IDLE (req=1). The result is presented
// with valid=1 and x_out/y_out stay stable until the consumer raises ack while
// valid=1; the block returns to IDLE on that edge. req while busy and ack
// outside HOLD have no effect.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   rnd    - LFSR output, advances every clock
//   req    - request a new position (IDLE only)
//   ack    - consumer accepts x_out/y_out while valid=1
//   busy   - high in every state except IDLE
//   valid  - x_out/y_out hold a new position, held until ack
//   x_out  - spawn x, always < X_MAX
//   y_out  - spawn y, always < Y_MAX
module spawn_pos_gen
    import game_pkg::*;
#(
    parameter int X_MAX   = SCREEN_W,
    parameter int Y_MAX   = SCREEN_H,
    parameter int XW      = COORD_XW,
    parameter int YW      = COORD_YW,
    parameter int MAX_TRY = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [12:0]   rnd,
    input  logic          req,
    input  logic          ack,
    output logic          busy,
    output logic          valid,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out
);

    localparam logic [XW-1:0] X_LIM    = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LIM    = YW'(Y_MAX);
    localparam logic [XW-1:0] X_TOP    = XW'(X_MAX - 1);
    localparam logic [3:0]    LAST_TRY = 4'(MAX_TRY - 1);

    spawn_state_e  state_q, state_d;
    logic [3:0]    try_cnt_q, try_cnt_d;
    logic [XW-1:0] x_raw_q, x_raw_d;
    logic [YW-1:0] y_raw_q, y_raw_d;
    logic [XW-1:0] last_x_q, last_x_d;
    logic [YW-1:0] last_y_q, last_y_d;
    logic          have_last_q, have_last_d;
    logic [XW-1:0] x_out_q, x_out_d;
    logic [YW-1:0] y_out_q, y_out_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    logic          in_range;
    logic          is_dup;
    logic          accept;
    logic [XW-1:0] x_fold;
    logic [YW-1:0] y_fold;
    logic [XW-1:0] x_fold_bumped;

    always_comb begin
        in_range = (x_raw_q < X_LIM) && (y_raw_q < Y_LIM);
        is_dup   = have_last_q && (x_raw_q == last_x_q) && (y_raw_q == last_y_q);
        accept   = in_range && !is_dup;

        // A single subtraction brings any raw value into range because
        // twice the bound exceeds the largest representable raw value.
        x_fold = (x_raw_q >= X_LIM) ? (x_raw_q - X_LIM) : x_raw_q;
        y_fold = (y_raw_q >= Y_LIM) ? (y_raw_q - Y_LIM) : y_raw_q;

        // Folded result colliding with the last position is nudged one
        // column right, wrapping at the screen edge.
        x_fold_bumped = x_fold;
        if (have_last_q && (x_fold == last_x_q) && (y_fold == last_y_q)) begin
            x_fold_bumped = (x_fold == X_TOP) ? '0 : (x_fold + XW'(1));
        end
    end

    always_comb begin
        state_d     = state_q;
        try_cnt_d   = try_cnt_q;
        x_raw_d     = x_raw_q;
        y_raw_d     = y_raw_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        have_last_d = have_last_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d   = ST_SAMPLE;
                    try_cnt_d = '0;
                end
            end
            ST_SAMPLE: begin
                // x and y fields share rnd bits 7:6 on purpose.
                x_raw_d = rnd[XW-1:0];
                y_raw_d = rnd[12 -: YW];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept) begin
                    x_out_d     = x_raw_q;
                    y_out_d     = y_raw_q;
                    last_x_d    = x_raw_q;
                    last_y_d    = y_raw_q;
                    have_last_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (try_cnt_q == LAST_TRY) begin
                    state_d = ST_FOLD;
                end else begin
                    try_cnt_d = try_cnt_q + 4'd1;
                    state_d   = ST_SAMPLE;
                end
            end
            ST_FOLD: begin
                x_out_d     = x_fold_bumped;
                y_out_d     = y_fold;
                last_x_d    = x_fold_bumped;
                last_y_d    = y_fold;
                have_last_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            try_cnt_q   <= '0;
            x_raw_q     <= '0;
            y_raw_q     <= '0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            have_last_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            try_cnt_q   <= try_cnt_d;
            x_raw_q     <= x_raw_d;
            y_raw_q     <= y_raw_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            have_last_q <= have_last_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign x_out = x_out_q;
    assign y_out = y_out_q;

endmodule

// File: tb/tb_spawn_pos_gen.sv
// Bench for spawn_pos_gen: directed scenarios plus randomized requests.
// The driver pre-builds the rnd stream of each request, runs a reference
// model over it, and pushes {x, y, cycle of first valid} into exp_q. The
// monitor pops an entry whenever valid rises and checks stability while valid.
module tb_spawn_pos_gen;

    localparam int MAX_TRY = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [12:0] rnd;
    logic        req;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [7:0]  x_out;
    logic [6:0]  y_out;

    spawn_pos_gen dut (
        .clock (clock),
        .reset (reset),
        .rnd   (rnd),
        .req   (req),
        .ack   (ack),
        .busy  (busy),
        .valid (valid),
        .x_out (x_out),
        .y_out (y_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    logic [46:0] exp_q[$];

    // ---------------- reference model ----------------
    int          m_have;
    int          m_lx;
    int          m_ly;
    logic [12:0] m_last_raw;
    logic [12:0] rnd_seq[32];

    // rnd_seq[i] is the value present at the i-th edge after the req edge.
    // Attempt k reads the value at edge 1+2k and, if accepted, is visible
    // after edge 2+2k. The fold fallback uses the last sample and is
    // visible after edge 2*MAX_TRY+1.
    task automatic model_run(output int ex, output int ey, output int elat);
        int x;
        int y;
        for (int k = 0; k < MAX_TRY; k++) begin
            x = int'(rnd_seq[1 + 2 * k]) % 256;
            y = int'(rnd_seq[1 + 2 * k]) / 64;
            if (x < 160 && y < 120 && !(m_have != 0 && x == m_lx && y == m_ly)) begin
                ex = x;
                ey = y;
                elat = 2 + 2 * k;
                m_have = 1;
                m_lx = x;
                m_ly = y;
                m_last_raw = rnd_seq[1 + 2 * k];
                return;
            end
        end
        x = int'(rnd_seq[2 * MAX_TRY - 1]) % 256;
        y = int'(rnd_seq[2 * MAX_TRY - 1]) / 64;
        if (x >= 160) x = x - 160;
        if (y >= 120) y = y - 120;
        if (m_have != 0 && x == m_lx && y == m_ly) x = (x == 159) ? 0 : x + 1;
        ex = x;
        ey = y;
        elat = 2 * MAX_TRY + 1;
        m_have = 1;
        m_lx = x;
        m_ly = y;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_valid = 1'b0;
    int          cur_x = 0;
    int          cur_y = 0;
    logic [46:0] mon_e;

    always @(negedge clock) begin
        if (!reset) begin
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pos_x", int'(x_out), int'(mon_e[46:39]));
                    check("pos_y", int'(y_out), int'(mon_e[38:32]));
                    check("latency_cycle", int'(cyc), int'(mon_e[31:0]));
                    cur_x <= int'(mon_e[46:39]);
                    cur_y <= int'(mon_e[38:32]);
                end
            end else if (valid) begin
                check("hold_x", int'(x_out), cur_x);
                check("hold_y", int'(y_out), cur_y);
            end
        end
        prev_valid <= valid;
    end

    // ---------------- driver tasks ----------------
    task automatic fill_seq(input logic [12:0] v);
        for (int i = 0; i < 32; i++) rnd_seq[i] = v;
    endtask

    task automatic fill_random();
        int mode;
        int sel;
        mode = $urandom_range(0, 3);
        for (int i = 0; i < 32; i++) begin
            sel = (mode == 0) ? 1 : $urandom_range(0, 3);
            case (sel)
                0: rnd_seq[i] = 13'($urandom_range(0, 8191));
                1: rnd_seq[i] = {5'($urandom_range(0, 31)), 8'($urandom_range(160, 255))};
                2: rnd_seq[i] = m_last_raw;
                default: rnd_seq[i] = {7'($urandom_range(120, 127)), 6'($urandom_range(0, 63))};
            endcase
        end
    endtask

    task automatic run_req(input int hold, input bit noise, input bit fixed,
                           input int fx, input int fy, input int flat,
                           input bit rst_in_hold);
        int ex;
        int ey;
        int el;
        bit seen;
        model_run(ex, ey, el);
        if (fixed) begin
            ex = fx;
            ey = fy;
            el = flat;
        end
        @(negedge clock);
        req = 1'b1;
        ack = 1'b0;
        rnd = rnd_seq[0];
        exp_q.push_back({8'(ex), 7'(ey), 32'(cyc + 1 + el)});
        seen = 1'b0;
        for (int i = 1; i <= 32 && !seen; i++) begin
            @(negedge clock);
            if (valid) begin
                seen = 1'b1;
            end else begin
                check("busy_during", int'(busy), 1);
                if (i < 32) rnd = rnd_seq[i];
            end
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (!seen) begin
            check("valid_timeout", 0, 1);
            reset = 1'b1;
            exp_q.delete();
            m_have = 0;
            @(negedge clock);
            reset = 1'b0;
            req = 1'b0;
            return;
        end
        check("busy_hold", int'(busy), 1);
        repeat (hold) begin
            @(negedge clock);
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rnd = 13'($urandom_range(0, 8191));
        end
        if (rst_in_hold) begin
            reset = 1'b1;
            #1;
            check("rst_valid", int'(valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_x", int'(x_out), 0);
            check("rst_y", int'(y_out), 0);
            m_have = 0;
            @(negedge clock);
            reset = 1'b0;
            req = 1'b0;
            return;
        end
        ack = 1'b1;
        req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clock);
        ack = 1'b0;
        req = 1'b0;
        check("valid_after_ack", int'(valid), 0);
        check("busy_after_ack", int'(busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        req = 1'b0;
        ack = 1'b0;
        rnd = '0;
        m_have = 0;
        m_lx = 0;
        m_ly = 0;
        m_last_raw = '0;
        #1;
        check("init_valid", int'(valid), 0);
        check("init_busy", int'(busy), 0);
        check("init_x", int'(x_out), 0);
        check("init_y", int'(y_out), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // First-try accept: 0x0450 -> (80,17) after edge +2, held 5 cycles.
        fill_seq(13'h0450);
        run_req(5, 0, 1, 80, 17, 2, 0);

        // Duplicate of (80,17) rejected, then 0x0001 -> (1,0); reset in HOLD.
        fill_seq(13'h0001);
        rnd_seq[0] = 13'h0450;
        rnd_seq[1] = 13'h0450;
        run_req(2, 0, 1, 1, 0, 4, 1);

        // After reset the previous position is forgotten: (1,0) accepted at once.
        fill_seq(13'h0001);
        run_req(1, 0, 1, 1, 0, 2, 0);

        // Off-screen first sample (x=255) rejected, 0x0450 accepted at edge +4.
        fill_seq(13'h0450);
        rnd_seq[0] = 13'h1FFF;
        rnd_seq[1] = 13'h1FFF;
        run_req(0, 0, 1, 80, 17, 4, 0);

        // All samples off-screen -> fold to (95,7); repeat -> bumped to (96,7).
        fill_seq(13'h1FFF);
        run_req(1, 1, 1, 95, 7, 31, 0);
        fill_seq(13'h1FFF);
        run_req(1, 1, 1, 96, 7, 31, 0);

        // ack in IDLE has no effect.
        repeat (3) begin
            @(negedge clock);
            ack = 1'b1;
            rnd = 13'($urandom_range(0, 8191));
        end
        @(negedge clock);
        ack = 1'b0;
        check("idle_ack_valid", int'(valid), 0);
        check("idle_ack_busy", int'(busy), 0);
        check("idle_ack_x", int'(x_out), m_lx);
        check("idle_ack_y", int'(y_out), m_ly);

        // Randomized requests with req noise while busy.
        for (int n = 0; n < 40; n++) begin
            fill_random();
            run_req($urandom_range(0, 4), 1, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clock);
                    ack = 1'b1;
                end
                @(negedge clock);
                ack = 1'b0;
                check("rand_idle_valid", int'(valid), 0);
            end
        end

        repeat (3) @(negedge clock);
        check("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
